axi_reg_responder: RTL and testbench

AXI4 slave that answers the 32-bit configuration-register bus (reg* channels, 15-bit address, 6-bit ID) with a bank of read/write registers. It is the responder end of the register AXI master in the core: it stands in for the DDR controller register space in simulation and in loopback builds, and gives software a scratch register window. It handles one transaction at a time, with burst, ID echo and error responses.

---
 rtl/axi_reg_responder.sv | 211 +++++++++++++++++++++
 tb/tb_axi_reg_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_responder.sv
// AXI4 register-bank responder for the 32-bit configuration bus.
// One transaction at a time; bursts, ID echo, per-beat and burst errors.
module axi_reg_responder #(
  parameter int          NREG    = 64,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        regACLK,
  input  logic        regARESETn,
  input  logic [14:0] regAWADDR,
  input  logic [5:0]  regAWID,
  input  logic [7:0]  regAWLEN,
  input  logic [2:0]  regAWSIZE,
  input  logic [1:0]  regAWBURST,
  input  logic        regAWVALID,
  output logic        regAWREADY,
  input  logic [31:0] regWDATA,
  input  logic [3:0]  regWSTRB,
  input  logic        regWLAST,
  input  logic        regWVALID,
  output logic        regWREADY,
  output logic [5:0]  regBID,
  output logic [1:0]  regBRESP,
  output logic        regBVALID,
  input  logic        regBREADY,
  input  logic [14:0] regARADDR,
  input  logic [5:0]  regARID,
  input  logic [7:0]  regARLEN,
  input  logic [2:0]  regARSIZE,
  input  logic [1:0]  regARBURST,
  input  logic        regARVALID,
  output logic        regARREADY,
  output logic [31:0] regRDATA,
  output logic [5:0]  regRID,
  output logic [1:0]  regRRESP,
  output logic        regRLAST,
  output logic        regRVALID,
  input  logic        regRREADY
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  logic [31:0] mem_q [NREG];
  state_e      state_q;
  logic        last_w_q;
  logic [5:0]  id_q;
  logic [14:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic        fixed_q;
  logic        err_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [5:0]  bid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [31:0] rdata_q;
  logic [5:0]  rid_q;
  logic [1:0]  rresp_q;

  logic          grant_w;
  logic          aw_hs;
  logic          ar_hs;
  logic          w_last;
  logic          w_ok;
  logic          err_d;
  logic [14:0]   addr_nxt;
  logic [14:0]   rd_addr;
  logic          rd_err;
  logic          rd_ok;
  logic [31:0]   rd_word;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          unused_ok;

  function automatic logic in_rng(input logic [12:0] w);
    return {1'b0, w} < 14'(NREG);
  endfunction

  // Tie goes to the side that lost last time
  assign grant_w = regAWVALID & (~regARVALID | ~last_w_q);
  assign aw_hs = regARESETn & (state_q == IDLE)
               & regAWVALID & grant_w;
  assign ar_hs = regARESETn & (state_q == IDLE)
               & regARVALID & ~grant_w;

  assign w_last   = (beat_q == len_q);
  assign wr_idx   = addr_q[IW+1:2];
  assign w_ok     = in_rng(addr_q[14:2]) & ~err_q;
  assign err_d    = err_q | ~w_ok | (regWLAST != w_last);
  assign addr_nxt = fixed_q ? addr_q : addr_q + 15'd4;

  // First read beat comes from the AR payload, later ones from addr_nxt
  assign rd_addr = (state_q == IDLE) ? regARADDR : addr_nxt;
  assign rd_err  = (state_q == IDLE) ? (regARSIZE != 3'b010) : err_q;
  assign rd_idx  = rd_addr[IW+1:2];
  assign rd_ok   = in_rng(rd_addr[14:2]) & ~rd_err;
  assign rd_word = rd_ok ? mem_q[rd_idx] : 32'h0;

  assign unused_ok = ^{rd_addr[1:0]};

  always_ff @(posedge regACLK) begin
    if (!regARESETn) begin
      state_q  <= IDLE;
      last_w_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= '0;
      for (int i = 0; i < NREG; i++) mem_q[i] <= RST_VAL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            state_q  <= WDATA;
            last_w_q <= 1'b1;
            id_q     <= regAWID;
            addr_q   <= regAWADDR;
            len_q    <= regAWLEN;
            beat_q   <= '0;
            fixed_q  <= (regAWBURST == 2'b00);
            err_q    <= (regAWSIZE != 3'b010);
            wready_q <= 1'b1;
          end else if (ar_hs) begin
            state_q  <= RDATA;
            last_w_q <= 1'b0;
            id_q     <= regARID;
            addr_q   <= regARADDR;
            len_q    <= regARLEN;
            beat_q   <= '0;
            fixed_q  <= (regARBURST == 2'b00);
            err_q    <= rd_err;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_ok ? 2'b00 : 2'b10;
            rid_q    <= regARID;
            rlast_q  <= (regARLEN == 8'd0);
          end
        end
        WDATA: begin
          if (regWVALID) begin
            if (w_ok) begin
              for (int b = 0; b < 4; b++) begin
                if (regWSTRB[b])
                  mem_q[wr_idx][8*b +: 8] <= regWDATA[8*b +: 8];
              end
            end
            err_q  <= err_d;
            addr_q <= addr_nxt;
            beat_q <= beat_q + 8'd1;
            if (w_last) begin
              state_q  <= WRESP;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= err_d ? 2'b10 : 2'b00;
            end
          end
        end
        WRESP: begin
          if (regBREADY) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        RDATA: begin
          if (regRREADY) begin
            if (rlast_q) begin
              state_q  <= IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              addr_q  <= addr_nxt;
              beat_q  <= beat_q + 8'd1;
              rdata_q <= rd_word;
              rresp_q <= rd_ok ? 2'b00 : 2'b10;
              rlast_q <= ((beat_q + 8'd1) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign regAWREADY = aw_hs;
  assign regARREADY = ar_hs;
  assign regWREADY  = wready_q;
  assign regBVALID  = bvalid_q;
  assign regBID     = bid_q;
  assign regBRESP   = bresp_q;
  assign regRVALID  = rvalid_q;
  assign regRDATA   = rdata_q;
  assign regRID     = rid_q;
  assign regRRESP   = rresp_q;
  assign regRLAST   = rlast_q;

endmodule

// File: tb/tb_axi_reg_responder.sv
// Directed bench for axi_reg_responder.
// Hand-computed expectations, one check task.
module tb_axi_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] awaddr;
  logic [5:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [14:0] araddr;
  logic [5:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [5:0]  rid;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_reg_responder #(.NREG(64), .RST_VAL(32'h0)) dut (
    .regACLK(clk), .regARESETn(rst_n),
    .regAWADDR(awaddr), .regAWID(awid), .regAWLEN(awlen),
    .regAWSIZE(awsize), .regAWBURST(awburst),
    .regAWVALID(awvalid), .regAWREADY(awready),
    .regWDATA(wdata), .regWSTRB(wstrb), .regWLAST(wlast),
    .regWVALID(wvalid), .regWREADY(wready),
    .regBID(bid), .regBRESP(bresp),
    .regBVALID(bvalid), .regBREADY(bready),
    .regARADDR(araddr), .regARID(arid), .regARLEN(arlen),
    .regARSIZE(arsize), .regARBURST(arburst),
    .regARVALID(arvalid), .regARREADY(arready),
    .regRDATA(rdata), .regRID(rid), .regRRESP(rresp),
    .regRLAST(rlast), .regRVALID(rvalid), .regRREADY(rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [5:0]  ri [16];

  logic [1:0] g_bresp;
  logic [5:0] g_bid;
  int         g_blat;
  int         g_rlat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aw();
    int n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_hs", awready, 1);
    step();
  endtask

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_hs", arready, 1);
    step();
  endtask

  task automatic w_phase(input int len, input bit bad_last);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      wdata  = wd[i];
      wstrb  = ws[i];
      wlast  = bad_last ? (i == 0) : (i == len);
      wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!wready) chk("w_hs", wready, 1);
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    g_blat = 0;
    @(negedge clk);
    while (!bvalid && g_blat < 20) begin
      @(negedge clk);
      g_blat++;
    end
    if (!bvalid) chk("b_hs", bvalid, 1);
    g_bresp = bresp;
    g_bid   = bid;
    step();
    bready = 1'b0;
  endtask

  task automatic r_phase(input int len, input bit toggle);
    int i = 0;
    int n = 0;
    bit first = 1'b1;
    logic [31:0] held = '0;
    g_rlat = -1;
    rready = !toggle;
    while (i <= len && n < 100) begin
      @(negedge clk);
      if (first && rvalid) begin
        g_rlat = n;
        first  = 1'b0;
      end
      if (rvalid && rready) begin
        rd[i] = rdata;
        rr[i] = rresp;
        rl[i] = rlast;
        ri[i] = rid;
        if (toggle) chk("r_hold", rdata, held);
        i++;
      end else if (rvalid) begin
        held = rdata;
      end
      step();
      if (toggle) rready = !rready;
      n++;
    end
    rready = 1'b0;
    chk("r_beats", i, len + 1);
  endtask

  task automatic do_write(input logic [14:0] a, input logic [5:0] id,
                          input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input bit bad_last);
    awaddr  = a;
    awid    = id;
    awlen   = 8'(len);
    awsize  = sz;
    awburst = bu;
    awvalid = 1'b1;
    wait_aw();
    awvalid = 1'b0;
    w_phase(len, bad_last);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [5:0] id,
                         input int len, input bit toggle);
    araddr  = a;
    arid    = id;
    arlen   = 8'(len);
    arsize  = 3'b010;
    arburst = 2'b01;
    arvalid = 1'b1;
    wait_ar();
    arvalid = 1'b0;
    r_phase(len, toggle);
  endtask

  task automatic read1(input logic [14:0] a, input string tag,
                       input logic [31:0] exp, input logic [1:0] exp_r);
    do_read(a, 6'h01, 0, 1'b0);
    chk({tag, "_d"}, rd[0], exp);
    chk({tag, "_r"}, 32'(rr[0]), 32'(exp_r));
  endtask

  // Both valids high; granted side must match exp_w
  task automatic arb_step(input bit exp_w, input logic [31:0] d);
    int n = 0;
    awaddr = 15'h0040; awid = 6'h05; awlen = 8'd0;
    awsize = 3'b010; awburst = 2'b01;
    araddr = 15'h0040; arid = 6'h06; arlen = 8'd0;
    arsize = 3'b010; arburst = 2'b01;
    awvalid = 1'b1;
    arvalid = 1'b1;
    @(negedge clk);
    while (!(awready || arready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arb_aw", awready, exp_w);
    chk("arb_ar", arready, !exp_w);
    step();
    if (exp_w) begin
      awvalid = 1'b0;
      wd[0] = d;
      ws[0] = 4'hF;
      w_phase(0, 1'b0);
    end else begin
      arvalid = 1'b0;
      r_phase(0, 1'b0);
      chk("arb_rdata", rd[0], d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {awaddr, awid, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {araddr, arid, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {bid, rid, bresp, rresp}, 0);
    step();
    rst_n = 1'b1;

    // Arbitration from reset: W, R, W, R
    arb_step(1'b1, 32'h1111_0000);
    arb_step(1'b0, 32'h1111_0000);
    arb_step(1'b1, 32'h1111_0002);
    arb_step(1'b0, 32'h1111_0002);
    awvalid = 1'b0;
    arvalid = 1'b0;

    // Single write/read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(15'h0010, 6'h2A, 0, 3'b010, 2'b01, 1'b0);
    chk("sw_bresp", 32'(g_bresp), 0);
    chk("sw_bid", 32'(g_bid), 32'h2A);
    chk("sw_blat", g_blat, 0);
    do_read(15'h0010, 6'h15, 0, 1'b0);
    chk("sr_data", rd[0], 32'hDEAD_BEEF);
    chk("sr_resp", 32'(rr[0]), 0);
    chk("sr_last", 32'(rl[0]), 1);
    chk("sr_id", 32'(ri[0]), 32'h15);
    chk("sr_lat", g_rlat, 0);

    // INCR burst with strobes over a primed register
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
    do_write(15'h0008, 6'h01, 0, 3'b010, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1);
      ws[i] = 4'hF;
    end
    ws[2] = 4'h3;
    do_write(15'h0000, 6'h03, 3, 3'b010, 2'b01, 1'b0);
    chk("ib_bresp", 32'(g_bresp), 0);
    do_read(15'h0000, 6'h09, 3, 1'b1);
    chk("ib_d0", rd[0], 32'h1);
    chk("ib_d1", rd[1], 32'h2);
    chk("ib_d2", rd[2], 32'hAABB_0003);
    chk("ib_d3", rd[3], 32'h4);
    chk("ib_last0", 32'(rl[0]), 0);
    chk("ib_last3", 32'(rl[3]), 1);
    chk("ib_resp", 32'({rr[0], rr[1], rr[2], rr[3]}), 0);

    // Out of range and size error
    wd[0] = 32'h1234_5678; wd[1] = 32'h0000_9999;
    ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(15'h00FC, 6'h04, 1, 3'b010, 2'b01, 1'b0);
    chk("oor_bresp", 32'(g_bresp), 2);
    read1(15'h00FC, "oor_b0", 32'h1234_5678, 2'b00);
    read1(15'h0100, "oor_rd", 32'h0, 2'b10);
    wd[0] = 32'h5555_5555;
    do_write(15'h0010, 6'h07, 0, 3'b011, 2'b01, 1'b0);
    chk("sz_bresp", 32'(g_bresp), 2);
    read1(15'h0010, "sz_keep", 32'hDEAD_BEEF, 2'b00);

    // FIXED burst and WLAST mismatch
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    do_write(15'h0008, 6'h08, 2, 3'b010, 2'b00, 1'b0);
    chk("fx_bresp", 32'(g_bresp), 0);
    do_read(15'h0008, 6'h0A, 1, 1'b0);
    chk("fx_d0", rd[0], 32'hC);
    chk("fx_d1", rd[1], 32'h4);
    wd[0] = 32'h77; wd[1] = 32'h88;
    do_write(15'h0030, 6'h0B, 1, 3'b010, 2'b01, 1'b1);
    chk("wl_bresp", 32'(g_bresp), 2);
    read1(15'h0030, "wl_b0", 32'h77, 2'b00);

    // Reset during beat 2 of a LEN=7 read
    araddr = 15'h0000; arid = 6'h11; arlen = 8'd7;
    arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b1;
    wait_ar();
    arvalid = 1'b0;
    rready  = 1'b1;
    step();
    step();
    chk("mid_valid", rvalid, 1);
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    rready = 1'b0;
    chk("mid_rvalid0", rvalid, 0);
    chk("mid_rlast0", rlast, 0);
    read1(15'h0010, "mid_r10", 32'h0, 2'b00);
    read1(15'h0000, "mid_r00", 32'h0, 2'b00);
    wd[0] = 32'h0000_CAFE; ws[0] = 4'hF;
    do_write(15'h0010, 6'h12, 0, 3'b010, 2'b01, 1'b0);
    chk("post_bresp", 32'(g_bresp), 0);
    read1(15'h0010, "post_rd", 32'h0000_CAFE, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
